// File: rtl/toom_cook_sched_pkg.sv
// Shared constants and types for the three-way split GF(2)[x] multiply scheduler.
// Segment geometry is derived from the operand width by the helper functions below.
package toom_pkg;

  function automatic int unsigned seg_k(int unsigned n);
    return (n + 2) / 3;
  endfunction

  // The top segment starts one bit lower when N mod 3 == 1, so that the two upper segments are equal.
  function automatic int unsigned seg_off2(int unsigned n);
    return 2 * seg_k(n) - 1 + (((n % 3) == 1) ? 0 : 1);
  endfunction

  localparam int unsigned N       = 409;
  localparam int unsigned K       = seg_k(N);
  localparam int unsigned Off0    = 0;
  localparam int unsigned Off1    = K;
  localparam int unsigned Off2    = seg_off2(N);
  localparam int unsigned W0      = Off1 - Off0;
  localparam int unsigned W1      = Off2 - Off1;
  localparam int unsigned W2      = N - Off2;
  localparam int unsigned NumProd = 9;
  localparam int unsigned KCntW   = $clog2(NumProd);
  localparam int unsigned BitCntW = $clog2(K);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMul,
    StAcc,
    StDone
  } state_e;

endpackage

// File: rtl/toom_cook_sched_gf2_serial_mul.sv
// Bit-serial carryless multiplier: one bit of a per enabled cycle, LSB first.
// The product register is cleared on load.
module gf2_serial_mul
  import toom_pkg::*;
#(
  parameter int unsigned W = K
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [W-1:0]    a_i,
  input  logic [W-1:0]    b_i,
  output logic [2*W-2:0]  prod_o
);

  localparam int unsigned PW = 2 * W - 1;

  logic [W-1:0]  a_q, a_d;
  logic [PW-1:0] b_q, b_d;
  logic [PW-1:0] prod_q, prod_d;

  // b is pre-shifted each cycle, so it always sits at the weight of the current a bit.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    prod_d = prod_q;
    if (load_i) begin
      a_d    = a_i;
      b_d    = PW'(b_i);
      prod_d = '0;
    end else if (en_i) begin
      prod_d = a_q[0] ? (prod_q ^ b_q) : prod_q;
      a_d    = a_q >> 1;
      b_d    = b_q << 1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/toom_cook_sched.sv
// Schedules the nine segment partial products of a carryless N x N multiply onto one
// serial GF(2) multiplier and accumulates them at their segment offsets.
module toom_cook_sched
  import toom_pkg::*;
#(
  parameter int unsigned N = toom_pkg::N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-2:0] c
);

  localparam int unsigned Seg     = seg_k(N);
  localparam int unsigned SegOff1 = Seg;
  localparam int unsigned SegOff2 = seg_off2(N);
  localparam int unsigned PW      = 2 * Seg - 1;
  localparam int unsigned AW      = 2 * N - 1;
  localparam int unsigned BitW    = $clog2(Seg);

  state_e           state_q;
  logic [KCntW-1:0] k_q;
  logic [1:0]       i_q, j_q;
  logic [BitW-1:0]  bit_q;
  logic [N-1:0]     a_q, b_q;
  logic [AW-1:0]    acc_q, c_q, acc_nxt;
  logic             busy_q, done_q;
  logic [Seg-1:0]   seg_a, seg_b;
  logic [PW-1:0]    prod;
  logic             mul_load, mul_en;

  function automatic int unsigned seg_off(logic [1:0] idx);
    case (idx)
      2'd0:    return 0;
      2'd1:    return SegOff1;
      default: return SegOff2;
    endcase
  endfunction

  function automatic int unsigned seg_w(logic [1:0] idx);
    case (idx)
      2'd0:    return Seg;
      2'd1:    return SegOff2 - SegOff1;
      default: return N - SegOff2;
    endcase
  endfunction

  // Narrow segments are zero-extended to Seg bits.
  function automatic logic [Seg-1:0] seg_of(logic [N-1:0] x, logic [1:0] idx);
    return Seg'(x >> seg_off(idx)) & ({Seg{1'b1}} >> (Seg - seg_w(idx)));
  endfunction

  always_comb begin
    seg_a   = seg_of(a_q, i_q);
    seg_b   = seg_of(b_q, j_q);
    acc_nxt = acc_q ^ (AW'(prod) << (seg_off(i_q) + seg_off(j_q)));
  end

  assign mul_load = (state_q == StLoad);
  assign mul_en   = (state_q == StMul);

  gf2_serial_mul #(
    .W (Seg)
  ) u_mul (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (mul_load),
    .en_i   (mul_en),
    .a_i    (seg_a),
    .b_i    (seg_b),
    .prod_o (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      bit_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          bit_q   <= '0;
          state_q <= StMul;
        end
        StMul: begin
          if (bit_q == BitW'(Seg - 1)) begin
            bit_q   <= '0;
            state_q <= StAcc;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        StAcc: begin
          acc_q <= acc_nxt;
          if (k_q == KCntW'(NumProd - 1)) begin
            // Result captured from the final accumulate so c is valid with done.
            c_q     <= acc_nxt;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            k_q <= k_q + 1'b1;
            if (j_q == 2'd2) begin
              j_q <= 2'd0;
              i_q <= i_q + 2'd1;
            end else begin
              j_q <= j_q + 2'd1;
            end
            state_q <= StLoad;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign c    = c_q;

endmodule

// File: tb/tb_toom_cook_sched.sv
// Directed bench for toom_cook_sched: latency, segment crossings, busy protection,
// abort and back-to-back operation against a plain bit-loop carryless reference.
module tb_toom_cook_sched;

  localparam int unsigned N  = 409;
  localparam int unsigned CW = 2 * N - 1;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  a     = '0;
  logic [N-1:0]  b     = '0;
  logic          busy;
  logic          done;
  logic [CW-1:0] c;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  toom_cook_sched #(
    .N (N)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  function automatic logic [CW-1:0] clmul(logic [N-1:0] x, logic [N-1:0] y);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (y[i]) r ^= (CW'(x) << i);
    return r;
  endfunction

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] r;
    r = '0;
    for (int w = 0; w < 13; w++) r = (r << 32) | N'($urandom());
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reports the 64-bit word holding the first differing bit.
  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    int idx;
    logic [63:0] ow, ew;
    idx = 0;
    for (int i = 0; i < CW; i++) begin
      if (obs[i] !== exp[i]) begin
        idx = i;
        break;
      end
    end
    ow = 64'(obs >> (idx / 64 * 64));
    ew = 64'(exp >> (idx / 64 * 64));
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h (word at bit %0d)", tag, ow, ew, idx / 64 * 64);
    end
  endtask

  task automatic go(input logic [N-1:0] av, input logic [N-1:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int t = 1; t <= 1400; t++) begin
      tick();
      if (done === 1'b1) begin
        cyc = t;
        break;
      end
    end
  endtask

  // Operands are scrambled right after acceptance; the result must not change.
  task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [CW-1:0] ev);
    int cyc;
    go(av, bv);
    a = ~av;
    b = rnd();
    wait_done(cyc);
    check({tag, "_lat"}, CW'(cyc), CW'(1251));
    check({tag, "_c"}, c, ev);
    tick();
  endtask

  initial begin
    logic [N-1:0]  av, bv, av2, bv2;
    logic [CW-1:0] ev;
    int cyc, nd, dt, g;
    logic busy_g1, busy_g2;

    #2;
    check("rst_busy", CW'(busy), CW'(0));
    check("rst_done", CW'(done), CW'(0));
    check("rst_c", c, CW'(0));
    tick();
    rst = 1'b0;

    // Identity; start sampled on the first edge after reset release.
    go(N'(1), N'(1));
    check("ident_accept", CW'(busy), CW'(1));
    wait_done(cyc);
    check("ident_lat", CW'(cyc), CW'(1251));
    check("ident_c", c, CW'(1));
    tick();
    check("ident_busy_after", CW'(busy), CW'(0));
    check("ident_done_after", CW'(done), CW'(0));
    check("ident_c_hold", c, CW'(1));

    av = '0; av[137] = 1'b1;
    bv = '0; bv[273] = 1'b1;
    ev = '0; ev[410] = 1'b1;
    run_op("cross_137_273", av, bv, ev);

    av = '0; av[408] = 1'b1;
    ev = '0; ev[816] = 1'b1;
    run_op("cross_408_408", av, av, ev);

    run_op("three_sq", N'(3), N'(3), CW'(5));

    for (int v = 0; v < 8; v++) begin
      av = rnd();
      bv = rnd();
      run_op($sformatf("rand%0d", v), av, bv, clmul(av, bv));
    end

    // Busy protection: start pulses in a MUL cycle and in the DONE cycle are ignored.
    av = rnd();
    bv = rnd();
    go(av, bv);
    nd = 0;
    dt = -1;
    for (int t = 1; t <= 1400; t++) begin
      if (t == 10 || t == 1252) begin
        a     = rnd();
        b     = rnd();
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        nd++;
        if (dt < 0) dt = t;
      end
    end
    check("busy_lat", CW'(dt), CW'(1251));
    check("busy_ndone", CW'(nd), CW'(1));
    check("busy_c", c, clmul(av, bv));
    check("busy_idle", CW'(busy), CW'(0));

    // Abort mid-operation; c was nonzero beforehand.
    go(rnd(), rnd());
    repeat (499) tick();
    rst = 1'b1;
    #1;
    check("abort_busy", CW'(busy), CW'(0));
    check("abort_c", c, CW'(0));
    check("abort_done", CW'(done), CW'(0));
    tick();
    rst = 1'b0;
    nd  = 0;
    for (int t = 0; t < 1300; t++) begin
      tick();
      if (done === 1'b1) nd++;
    end
    check("abort_nodone", CW'(nd), CW'(0));
    av = rnd();
    bv = rnd();
    run_op("after_abort", av, bv, clmul(av, bv));

    // Back-to-back with start held high.
    av = rnd();
    bv = rnd();
    av2 = rnd();
    bv2 = rnd();
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    wait_done(cyc);
    check("b2b_lat1", CW'(cyc), CW'(1251));
    check("b2b_c1", c, clmul(av, bv));
    a = av2;
    b = bv2;
    g = 0;
    busy_g1 = 1'b1;
    busy_g2 = 1'b0;
    for (int t = 1; t <= 1400; t++) begin
      tick();
      g = t;
      if (t == 1) busy_g1 = busy;
      if (t == 2) busy_g2 = busy;
      if (done === 1'b1) break;
    end
    start = 1'b0;
    check("b2b_idle_gap", CW'(busy_g1), CW'(0));
    check("b2b_accept", CW'(busy_g2), CW'(1));
    // Cycles strictly between the two done pulses.
    check("b2b_gap", CW'(g - 1), CW'(1252));
    check("b2b_c2", c, clmul(av2, bv2));
    tick();
    tick();
    check("b2b_stop", CW'(busy), CW'(0));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
